// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MEM stage.
//   state_t : MEM-stage FSM encoding (IDLE / ACCESS / WB)
//   ctrl_t  : control-bit bundle captured from EX
//   DW_DEF / RW_DEF : default datapath and register-address widths
//   is_mem_op : true when an op needs the data-memory port
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
  } ctrl_t;

  function automatic logic is_mem_op(input ctrl_t c);
    return c.memread | c.memwrite;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, data-memory access and branch resolution.
//
// Handshake: EX presents an op with ex_valid; the op is captured on any
// rising edge where ex_valid && ex_ready. ex_valid may be held while
// ex_ready is low; nothing is captured until both are high on the same edge.
// The data-memory port is req/ack: dmem_req stays high with stable
// addr/we/wdata until the edge where dmem_ack is seen high.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_*                       EX-stage outputs and control bits, ex_ready back
//   pc_src, pc_target          branch-taken pulse and its target
//   dmem_*                     data-memory request port
//   wb_*                       MEM/WB result presented to write-back
//   mem_err                    sticky memory-timeout flag
//   state_dbg                  current FSM state (observation only)
//
// Configuration macro: MEM_TIMEOUT_EN. When defined, an ACCESS that sees no
// ack within TIMEOUT_CYCLES cycles is abandoned: dmem_req drops, mem_err sets
// (sticky until reset) and the op retires through WB with wb_regwrite = 0.
// When undefined, ACCESS waits indefinitely and mem_err is constant 0.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int RW             = RW_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_aluout,
  input  logic          ex_zero,
  input  logic [RW-1:0] ex_wreg,
  input  logic [DW-1:0] ex_btarget,
  input  logic [DW-1:0] ex_wdata,
  input  logic          ex_branch,
  input  logic          ex_memread,
  input  logic          ex_memwrite,
  input  logic          ex_regwrite,
  input  logic          ex_memtoreg,
  output logic          pc_src,
  output logic [DW-1:0] pc_target,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          wb_valid,
  output logic          wb_regwrite,
  output logic [RW-1:0] wb_wreg,
  output logic [DW-1:0] wb_data,
  output logic          mem_err,
  output state_t        state_dbg
);

  state_t        state_q, state_d;
  ctrl_t         ctrl_in, ctrl_q;
  logic [DW-1:0] alu_q, btarget_q, wdata_q, rdata_q;
  logic [RW-1:0] wreg_q;
  logic          zero_q;
  logic          cap, cap_d1_q;
  logic          in_access, in_wb;
  logic          timeout_hit;
  logic          tmo_q;
  logic          err_q;

  assign ctrl_in = '{branch:   ex_branch,
                     memread:  ex_memread,
                     memwrite: ex_memwrite,
                     regwrite: ex_regwrite,
                     memtoreg: ex_memtoreg};

  assign in_access = (state_q == ST_ACCESS);
  assign in_wb     = (state_q == ST_WB);
  assign ex_ready  = (state_q == ST_IDLE) || in_wb;
  assign cap       = ex_valid && ex_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cap) state_d = is_mem_op(ctrl_in) ? ST_ACCESS : ST_WB;
      end
      ST_ACCESS: begin
        if (dmem_ack || timeout_hit) state_d = ST_WB;
      end
      ST_WB: begin
        if (cap) state_d = is_mem_op(ctrl_in) ? ST_ACCESS : ST_WB;
        else     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and EX/MEM capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      alu_q     <= '0;
      btarget_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wreg_q    <= '0;
      zero_q    <= 1'b0;
      cap_d1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_d1_q <= cap;
      if (cap) begin
        ctrl_q    <= ctrl_in;
        alu_q     <= ex_aluout;
        btarget_q <= ex_btarget;
        wdata_q   <= ex_wdata;
        wreg_q    <= ex_wreg;
        zero_q    <= ex_zero;
      end
      // Acks outside ACCESS belong to no live transaction and are dropped.
      if (in_access && dmem_ack) rdata_q <= dmem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;

  // cnt_q counts completed ACCESS cycles without ack; the abort edge is the
  // end of the TIMEOUT_CYCLES-th ACCESS cycle, so dmem_req is high exactly
  // TIMEOUT_CYCLES cycles.
  assign timeout_hit = in_access && !dmem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (cap) begin
        cnt_q <= '0;
        tmo_q <= 1'b0;
      end else if (in_access && !dmem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        tmo_q <= 1'b1;
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign tmo_q       = 1'b0;
  assign err_q       = 1'b0;
`endif

  // Branch resolves from the captured op, one cycle after capture.
  assign pc_src    = cap_d1_q && ctrl_q.branch && zero_q;
  assign pc_target = btarget_q;

  assign dmem_req   = in_access;
  assign dmem_we    = in_access && ctrl_q.memwrite;
  assign dmem_addr  = in_access ? alu_q   : '0;
  assign dmem_wdata = in_access ? wdata_q : '0;

  // A write (including memread+memwrite) never updates the register file;
  // load data is only meaningful for a pure read.
  assign wb_valid    = in_wb;
  assign wb_regwrite = in_wb && ctrl_q.regwrite && !ctrl_q.memwrite && !tmo_q;
  assign wb_wreg     = in_wb ? wreg_q : '0;
  assign wb_data     = !in_wb ? '0 :
                       (ctrl_q.memtoreg && ctrl_q.memread && !ctrl_q.memwrite) ? rdata_q : alu_q;

  assign mem_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, away from the edge.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_ready;
  logic [DW-1:0] ex_aluout, ex_btarget, ex_wdata;
  logic          ex_zero;
  logic [RW-1:0] ex_wreg;
  logic          ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic          pc_src;
  logic [DW-1:0] pc_target;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          wb_valid, wb_regwrite;
  logic [RW-1:0] wb_wreg;
  logic [DW-1:0] wb_data;
  logic          mem_err;
  state_t        state_dbg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.DW(DW), .RW(RW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluout(ex_aluout), .ex_zero(ex_zero), .ex_wreg(ex_wreg),
    .ex_btarget(ex_btarget), .ex_wdata(ex_wdata),
    .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .pc_src(pc_src), .pc_target(pc_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .wb_data(wb_data), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_aluout = '0; ex_zero = 0; ex_wreg = '0; ex_btarget = '0;
    ex_wdata = '0; ex_branch = 0; ex_memread = 0; ex_memwrite = 0;
    ex_regwrite = 0; ex_memtoreg = 0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
    clear_ex();
    ex_valid = 1; ex_aluout = res; ex_wreg = rd; ex_regwrite = 1;
  endtask

  initial begin
    rst_n = 0; dmem_ack = 0; dmem_rdata = '0;
    clear_ex();
    #1;
    step(); step();

    // Reset state
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    rst_n = 1;
    step();

    // 1: ALU op, one-cycle latency
    alu_op(32'h10, 5'd5);
    step();
    clear_ex();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_wreg", wb_wreg, 5);
    chk("alu_wb_data", wb_data, 32'h10);
    chk("alu_wb_regwrite", wb_regwrite, 1);
    chk("alu_no_req", dmem_req, 0);
    step();
    chk("alu_back_idle", wb_valid, 0);
    chk("alu_idle_state", state_dbg, ST_IDLE);

    // Back-to-back ALU ops: capture in WB, no bubble
    alu_op(32'hA, 5'd1);
    step();
    chk("b2b_a_data", wb_data, 32'hA);
    chk("b2b_a_ready", ex_ready, 1);
    alu_op(32'hB, 5'd2);
    step();
    clear_ex();
    chk("b2b_b_valid", wb_valid, 1);
    chk("b2b_b_data", wb_data, 32'hB);
    chk("b2b_b_wreg", wb_wreg, 2);
    step();
    chk("b2b_idle", wb_valid, 0);

    // Ack outside ACCESS ignored
    dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
    step();
    dmem_ack = 0;
    chk("stray_ack_valid", wb_valid, 0);
    chk("stray_ack_state", state_dbg, ST_IDLE);

    // 2: load, ack in third ACCESS cycle
    clear_ex();
    ex_valid = 1; ex_aluout = 32'h100; ex_wreg = 5'd7;
    ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1;
    step();
    clear_ex();
    chk("ld_req1", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_ready_low", ex_ready, 0);
    step();
    chk("ld_req2", dmem_req, 1);
    step();
    chk("ld_req3", dmem_req, 1);
    chk("ld_addr3", dmem_addr, 32'h100);
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 0; dmem_rdata = '0;
    chk("ld_req_drop", dmem_req, 0);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_wreg", wb_wreg, 7);
    chk("ld_wb_regwrite", wb_regwrite, 1);
    step();
    chk("ld_idle", wb_valid, 0);

    // 3: store, ack in second ACCESS cycle
    clear_ex();
    ex_valid = 1; ex_aluout = 32'h200; ex_wdata = 32'h1234; ex_memwrite = 1;
    step();
    clear_ex();
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h200);
    chk("st_wdata", dmem_wdata, 32'h1234);
    step();
    chk("st_addr_hold", dmem_addr, 32'h200);
    chk("st_wdata_hold", dmem_wdata, 32'h1234);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_regwrite", wb_regwrite, 0);
    step();

    // memread+memwrite with regwrite: write only, ack first ACCESS cycle
    clear_ex();
    ex_valid = 1; ex_aluout = 32'h300; ex_wdata = 32'h77; ex_memread = 1;
    ex_memwrite = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_wreg = 5'd9;
    step();
    clear_ex();
    chk("rw_we", dmem_we, 1);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_0000;
    step();
    dmem_ack = 0;
    chk("rw_wb_valid", wb_valid, 1);
    chk("rw_wb_regwrite", wb_regwrite, 0);
    step();

    // 4: branch taken and not taken
    clear_ex();
    ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_btarget = 32'h40;
    step();
    clear_ex();
    chk("br_pc_src", pc_src, 1);
    chk("br_pc_target", pc_target, 32'h40);
    step();
    chk("br_pulse_end", pc_src, 0);
    clear_ex();
    ex_valid = 1; ex_branch = 1; ex_zero = 0; ex_btarget = 32'h80;
    step();
    clear_ex();
    chk("br_nt_pc_src", pc_src, 0);
    step();
    chk("br_nt_pc_src2", pc_src, 0);

    // 5: reset during ACCESS, then late ack
    clear_ex();
    ex_valid = 1; ex_aluout = 32'h400; ex_memread = 1; ex_regwrite = 1; ex_wreg = 5'd3;
    step();
    clear_ex();
    chk("rsta_req", dmem_req, 1);
    rst_n = 0;
    step();
    chk("rsta_req_drop", dmem_req, 0);
    chk("rsta_state", state_dbg, ST_IDLE);
    rst_n = 1; dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    step();
    dmem_ack = 0;
    chk("rsta_late_valid", wb_valid, 0);
    chk("rsta_late_state", state_dbg, ST_IDLE);
    step();
    chk("rsta_late_valid2", wb_valid, 0);

    // 6: no ack
    clear_ex();
    ex_valid = 1; ex_aluout = 32'h500; ex_memread = 1; ex_memtoreg = 1;
    ex_regwrite = 1; ex_wreg = 5'd4;
    step();
    clear_ex();
    chk("to_req1", dmem_req, 1);
    step(); step(); step();
    chk("to_req4", dmem_req, 1);
    step();
`ifdef MEM_TIMEOUT_EN
    chk("to_req_drop", dmem_req, 0);
    chk("to_mem_err", mem_err, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_regwrite", wb_regwrite, 0);
    step();
    chk("to_err_sticky", mem_err, 1);
    chk("to_idle", state_dbg, ST_IDLE);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("to_err_clear", mem_err, 0);
`else
    for (int i = 0; i < 6; i++) step();
    chk("wait_req_held", dmem_req, 1);
    chk("wait_no_err", mem_err, 0);
    chk("wait_no_wb", wb_valid, 0);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_ack = 0;
    chk("wait_wb_data", wb_data, 32'hCAFE_F00D);
    chk("wait_wb_regwrite", wb_regwrite, 1);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
